// File: rtl/updown_counter_param_sync_rst.sv
// Parametrised up/down counter with load, programmable step,
// wrap/saturate mode, registered zero/max flags and boundary pulse.
module updown_counter_param_sync_rst #(
    parameter int unsigned           WIDTH     = 16,
    parameter int unsigned           STEP      = 1,
    parameter bit                    SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0]      RST_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clock0,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             is_zero,
    output logic             is_max,
    output logic             boundary
);

    localparam logic [WIDTH-1:0] STEP_N  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZER = {WIDTH{1'b0}};

    // up path carries one extra bit so the carry-out marks overflow
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             ovf;
    logic             unf;

    logic [WIDTH-1:0] count_nxt;
    logic             bnd_nxt;
    logic             zero_nxt;
    logic             max_nxt;

    // step arithmetic and crossing detection
    always_comb begin
        sum  = {1'b0, count} + {1'b0, STEP_N};
        diff = count - STEP_N;
        ovf  = sum[WIDTH];
        unf  = (count < STEP_N);
    end

    // next count and boundary: load beats enable, otherwise hold
    always_comb begin
        count_nxt = count;
        bnd_nxt   = 1'b0;
        if (load) begin
            count_nxt = load_value;
        end else if (enable) begin
            if (up_down) begin
                bnd_nxt = ovf;
                if (ovf && SATURATE)
                    count_nxt = ALL_ONE;
                else
                    count_nxt = sum[WIDTH-1:0];
            end else begin
                bnd_nxt = unf;
                if (unf && SATURATE)
                    count_nxt = ALL_ZER;
                else
                    count_nxt = diff;
            end
        end
    end

    // flags come from the next count so they line up with it
    always_comb begin
        zero_nxt = (count_nxt == ALL_ZER);
        max_nxt  = (count_nxt == ALL_ONE);
    end

    // state register with synchronous active-low reset
    always_ff @(posedge clock0) begin
        if (!reset) begin
            count    <= RST_VALUE;
            is_zero  <= (RST_VALUE == ALL_ZER);
            is_max   <= (RST_VALUE == ALL_ONE);
            boundary <= 1'b0;
        end else begin
            count    <= count_nxt;
            is_zero  <= zero_nxt;
            is_max   <= max_nxt;
            boundary <= bnd_nxt;
        end
    end

endmodule
